iter_adder: RTL

ITER_ADDER -- requirements
Module: iter_adder

---
 rtl/iter_adder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/iter_adder.sv
// Multi-cycle ripple adder/subtractor: CHUNK bits per clock, LSB chunk first.
// Results hold from DONE until the next accepted start.
module iter_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_out, c_msb;
  logic             last;

  always_comb begin
    a_ch = a_q[idx_q*CHUNK +: CHUNK];
    b_ch = b_q[idx_q*CHUNK +: CHUNK];
    {c_out, s_ch} = {1'b0, a_ch}
                  + {1'b0, b_ch}
                  + {{CHUNK{1'b0}}, carry_q};
    // carry into the top bit of this chunk, recovered from its sum bit
    c_msb = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    last = (idx_q == IW'(NCHUNK - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : Cin;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = s_ch;
        carry_d = c_out;
        if (last) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule
